pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Datapath-side responder to the CPU control FSM. It owns the program counter and the instruction register.
- Acts on PS/BC/IL/EOE strobes from control, the ALU zero flag, and branch/jump operands.
- Runs a req/ack handshake with instruction memory. It supplies the fetched instruction and the current PC (plus PC+1 for link writes) back to the decoder and datapath.

Parameters:
- PC_WIDTH, 8, program counter and instruction address width
- INSTR_WIDTH, 16, instruction word width
- OFF_WIDTH, 8, signed relative branch offset width, sign-extended to PC_WIDTH
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- PS  in  2  PC select: 0 hold, 1 increment, 2 relative jump, 3 absolute jump
- BC  in  1  branch condition for PS=2: 0 take if zero=1, 1 take if zero=0
- IL  in  1  instruction load request from control
- EOE  in  1  end of execution; halts the unit
- zero  in  1  ALU zero flag
- offset  in  OFF_WIDTH  signed relative displacement
- target  in  PC_WIDTH  absolute jump address
- imem_req  out  1  instruction memory request (registered)
- imem_addr  out  PC_WIDTH  fetch address (registered)
- imem_rdata  in  INSTR_WIDTH  instruction memory read data
- imem_ack  in  1  memory has valid data this cycle
- instr  out  INSTR_WIDTH  instruction register
- instr_valid  out  1  one-cycle pulse when instr was updated
- pc  out  PC_WIDTH  current program counter
- pc_plus1  out  PC_WIDTH  combinational pc+1 (link value)
- busy  out  1  fetch outstanding
- halted  out  1  unit halted by EOE

Behaviour:
- Reset (reset==0 at an edge) sets: pc=RESET_PC, instr=0, imem_req=0, imem_addr=0, instr_valid=0, busy=0, halted=0, state=IDLE.
- States: IDLE, WAIT, HALT. busy=1 exactly in WAIT; halted=1 exactly in HALT.
- IDLE, on each edge:
  - If EOE=1, go to HALT. EOE has priority over IL and PS. PC and instr hold.
  - Else if IL=1: imem_addr<=pc (value before this edge's PC update), imem_req<=1, go to WAIT.
  - PC update applies on the same edge, independent of IL:
    - PS=0: pc holds.
    - PS=1: pc<=pc+1.
    - PS=2: if taken, pc<=pc+sext(offset); else pc<=pc+1. Taken means (BC=0 and zero=1) or (BC=1 and zero=0).
    - PS=3: pc<=target.
- WAIT:
  - PS, IL and EOE are ignored; pc holds.
  - imem_req and imem_addr stay stable until imem_ack is sampled high.
  - On the ack edge: instr<=imem_rdata, instr_valid<=1 for one cycle, imem_req<=0, go to IDLE.
  - Minimum latency: IL sampled at edge k; req high in cycle k..k+1; ack in that cycle gives instr and instr_valid after edge k+1.
  - Zero-wait ack is allowed. Unbounded wait states are allowed; there is no timeout.
- imem_ack while imem_req=0 is ignored.
- HALT is sticky until reset. imem_req=0, pc and instr are frozen, all inputs are ignored.
- Arithmetic: all PC arithmetic is modulo 2^PC_WIDTH, wrap silently. offset is two's complement; negative offsets move backward.
- pc_plus1 = pc+1 mod 2^PC_WIDTH, combinational from the pc register.
- Reset mid-fetch: imem_req drops at the reset edge, and any ack in the following cycle is discarded.
- EOE is only honoured in IDLE. An EOE arriving during WAIT is lost, so control must re-present it.

Test Plan:
- Reset then idle: hold reset low 2 cycles, release, PS=0, IL=0 -> pc=0, imem_req=0, instr=0, halted=0, busy=0.
- Sequential fetch: PS=1, IL=1 one cycle, ack returned 1 cycle later with rdata=16'hA5C3 -> imem_addr=0, pc=1, instr=16'hA5C3, instr_valid single pulse, busy high for 1 cycle.
- Relative branches at pc=8'h10:
  - offset=8'hFC (-4), BC=0, zero=1, PS=2 -> pc=8'h0C.
  - Same with zero=0 -> pc=8'h11.
  - BC=1, zero=0, offset=5 -> pc=8'h15.
- Absolute jump and link: pc=8'h20, PS=3, target=8'h80 -> pc_plus1=8'h21 before the edge, pc=8'h80 after; pc=8'hFF with PS=1 -> wraps to 8'h00.
- Wait states: IL=1, ack withheld 5 cycles while PS=1 and EOE=1 are toggled -> pc unchanged, imem_req stable, no halt; after ack, instr loads and state returns to IDLE.
- Halt and reset mid-fetch:
  - EOE=1 in IDLE -> halted=1; later IL/PS activity changes nothing.
  - reset low during WAIT -> imem_req=0 next cycle, a late ack is ignored, pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction register owner.
// Responds to the control FSM's PC-select, instruction-load and end-of-execution
// strobes. Runs a req/ack fetch handshake with instruction memory and returns
// the fetched word plus the current PC and its link value (PC+1).
module pc_fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int OFF_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             PS,
    input  logic                   BC,
    input  logic                   IL,
    input  logic                   EOE,
    input  logic                   zero,
    input  logic [OFF_WIDTH-1:0]   offset,
    input  logic [PC_WIDTH-1:0]    target,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_ack,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus1,
    output logic                   busy,
    output logic                   halted
);

    // PC-select encodings
    localparam logic [1:0] PS_HOLD = 2'd0;
    localparam logic [1:0] PS_INC  = 2'd1;
    localparam logic [1:0] PS_REL  = 2'd2;
    localparam logic [1:0] PS_ABS  = 2'd3;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // IDLE accepts strobes, WAIT holds a fetch outstanding, HALT is terminal until reset
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic                   valid_q, valid_d;

    logic [PC_WIDTH-1:0]    off_ext;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    pc_upd;

    // Sign-extend (or truncate) the relative displacement to the PC width;
    // wrap-around falls out of the modulo-2^PC_WIDTH add.
    generate
        if (PC_WIDTH > OFF_WIDTH) begin : g_off_sext
            assign off_ext = {{(PC_WIDTH-OFF_WIDTH){offset[OFF_WIDTH-1]}}, offset};
        end else begin : g_off_trunc
            assign off_ext = offset[PC_WIDTH-1:0];
        end
    endgenerate

    assign pc_inc = pc_q + PC_ONE;

    // BC=0 branches on zero set, BC=1 branches on zero clear
    assign branch_taken = BC ? ~zero : zero;

    // Candidate PC for an IDLE edge, selected by PS
    always_comb begin
        pc_upd = pc_q;
        case (PS)
            PS_HOLD: pc_upd = pc_q;
            PS_INC:  pc_upd = pc_inc;
            PS_REL:  pc_upd = branch_taken ? (pc_q + off_ext) : pc_inc;
            PS_ABS:  pc_upd = target;
            default: pc_upd = pc_q;
        endcase
    end

    // Next-state logic: strobes are honoured only in IDLE; WAIT only watches ack
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EOE) begin
                    // End of execution wins over IL and PS; everything freezes
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_upd;
                    if (IL) begin
                        // Fetch address is the PC before this edge's update
                        addr_d  = pc_q;
                        req_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // req/addr held stable until the ack edge; strobes are dropped here
                if (imem_ack && req_q) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                req_d = 1'b0;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus1    = pc_inc;
    assign busy        = (state_q == ST_WAIT);
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the unit.
module tb_pc_fetch_unit;

    localparam int PW = 8;
    localparam int IW = 16;
    localparam int OW = 8;
    localparam logic [PW-1:0] RP = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    PS;
    logic          BC, IL, EOE, zero;
    logic [OW-1:0] offset;
    logic [PW-1:0] target;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ack;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [PW-1:0] pc, pc_plus1;
    logic          busy, halted;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFF_WIDTH(OW), .RESET_PC(RP)
    ) dut (
        .clk(clk), .reset(reset), .PS(PS), .BC(BC), .IL(IL), .EOE(EOE),
        .zero(zero), .offset(offset), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus1(pc_plus1), .busy(busy), .halted(halted)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural view of the unit
    logic [PW-1:0] m_pc;
    logic [IW-1:0] m_instr;
    logic          m_req;
    logic [PW-1:0] m_addr;
    logic          m_valid;
    logic          m_pending;  // a fetch has been issued and not yet answered
    logic          m_halted;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        int next_pc;
        if (!reset) begin
            m_pc = RP; m_instr = '0; m_req = 1'b0; m_addr = '0;
            m_valid = 1'b0; m_pending = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (m_pending) begin
            m_valid = 1'b0;
            if (imem_ack) begin
                m_instr = imem_rdata; m_valid = 1'b1;
                m_pending = 1'b0; m_req = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            if (EOE) begin
                m_halted = 1'b1;
            end else begin
                if (IL) begin
                    m_addr = m_pc; m_req = 1'b1; m_pending = 1'b1;
                end
                next_pc = int'(m_pc);
                if (PS == 2'd1) next_pc = next_pc + 1;
                else if (PS == 2'd3) next_pc = int'(target);
                else if (PS == 2'd2) begin
                    if ((BC == 1'b0 && zero == 1'b1) || (BC == 1'b1 && zero == 1'b0))
                        next_pc = next_pc + int'($signed(offset));
                    else
                        next_pc = next_pc + 1;
                end
                m_pc = PW'(next_pc);
            end
        end
    endtask

    // One clock: update model, let the edge happen, compare all outputs
    task automatic tick();
        logic [PW-1:0] exp_p1;
        model_edge();
        @(posedge clk);
        #1;
        exp_p1 = m_pc + 8'd1;
        check_val("pc", pc, m_pc);
        check_val("pc_plus1", pc_plus1, exp_p1);
        check_val("instr", instr, m_instr);
        check_val("instr_valid", instr_valid, m_valid);
        check_val("imem_req", imem_req, m_req);
        check_val("imem_addr", imem_addr, m_addr);
        check_val("busy", busy, m_pending);
        check_val("halted", halted, m_halted);
        if (m_valid) $display("fetch addr=%02h instr=%04h pc=%02h", m_addr, m_instr, m_pc);
    endtask

    task automatic set_idle();
        PS = 2'd0; IL = 1'b0; EOE = 1'b0; BC = 1'b0; zero = 1'b0;
        offset = '0; target = '0; imem_ack = 1'b0; imem_rdata = '0;
    endtask

    task automatic load_pc(input logic [PW-1:0] v);
        set_idle(); PS = 2'd3; target = v; tick();
        check_val("load_pc", pc, v);
    endtask

    initial begin
        m_pc = RP; m_instr = '0; m_req = 1'b0; m_addr = '0;
        m_valid = 1'b0; m_pending = 1'b0; m_halted = 1'b0;
        set_idle();

        // Reset then idle
        reset = 1'b0; tick(); tick();
        reset = 1'b1; tick();
        check_val("rst_pc", pc, 8'h00);
        check_val("rst_req", imem_req, 1'b0);
        check_val("rst_instr", instr, 16'h0000);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_busy", busy, 1'b0);

        // Sequential fetch with one-cycle ack
        PS = 2'd1; IL = 1'b1; tick();
        check_val("seq_addr", imem_addr, 8'h00);
        check_val("seq_pc", pc, 8'h01);
        check_val("seq_busy", busy, 1'b1);
        set_idle(); imem_ack = 1'b1; imem_rdata = 16'hA5C3; tick();
        check_val("seq_instr", instr, 16'hA5C3);
        check_val("seq_valid", instr_valid, 1'b1);
        check_val("seq_busy_done", busy, 1'b0);
        set_idle(); tick();
        check_val("seq_valid_pulse", instr_valid, 1'b0);

        // Relative branches from 0x10
        load_pc(8'h10);
        set_idle(); PS = 2'd2; offset = 8'hFC; BC = 1'b0; zero = 1'b1; tick();
        check_val("br_back_taken", pc, 8'h0C);
        load_pc(8'h10);
        set_idle(); PS = 2'd2; offset = 8'hFC; BC = 1'b0; zero = 1'b0; tick();
        check_val("br_not_taken", pc, 8'h11);
        load_pc(8'h10);
        set_idle(); PS = 2'd2; offset = 8'h05; BC = 1'b1; zero = 1'b0; tick();
        check_val("br_bc1_taken", pc, 8'h15);

        // Absolute jump, link value, wrap
        load_pc(8'h20);
        check_val("link", pc_plus1, 8'h21);
        set_idle(); PS = 2'd3; target = 8'h80; tick();
        check_val("jump", pc, 8'h80);
        load_pc(8'hFF);
        check_val("link_wrap", pc_plus1, 8'h00);
        set_idle(); PS = 2'd1; tick();
        check_val("inc_wrap", pc, 8'h00);

        // Wait states with strobes toggling
        set_idle(); IL = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            set_idle(); PS = 2'd1; IL = 1'b1; EOE = i[0]; tick();
            check_val("wait_pc", pc, 8'h00);
            check_val("wait_req", imem_req, 1'b1);
            check_val("wait_halt", halted, 1'b0);
        end
        set_idle(); imem_ack = 1'b1; imem_rdata = 16'h1234; tick();
        check_val("wait_instr", instr, 16'h1234);
        check_val("wait_idle", busy, 1'b0);

        // Halt, then ignore activity
        set_idle(); EOE = 1'b1; PS = 2'd1; IL = 1'b1; tick();
        check_val("halt", halted, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_idle(); PS = 2'd1; IL = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF; tick();
        end
        check_val("halt_pc", pc, 8'h00);
        check_val("halt_req", imem_req, 1'b0);
        check_val("halt_instr", instr, 16'h1234);

        // Reset during a fetch; a late ack is dropped
        set_idle(); reset = 1'b0; tick();
        reset = 1'b1; load_pc(8'h42);
        set_idle(); IL = 1'b1; tick();
        check_val("mid_req", imem_req, 1'b1);
        set_idle(); reset = 1'b0; tick();
        check_val("mid_req_drop", imem_req, 1'b0);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD; tick();
        check_val("mid_instr", instr, 16'h0000);
        check_val("mid_valid", instr_valid, 1'b0);
        check_val("mid_pc", pc, RP);

        // Randomized run
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 79) != 0);
            EOE        = ($urandom_range(0, 39) == 0);
            PS         = 2'($urandom_range(0, 3));
            IL         = ($urandom_range(0, 2) == 0);
            BC         = 1'($urandom_range(0, 1));
            zero       = 1'($urandom_range(0, 1));
            offset     = OW'($urandom);
            target     = PW'($urandom);
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = IW'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
